// File: rtl/qpu_pkg.sv
// Shared definitions for the COP2 quantum issue path: gate codes, instruction
// field constants, per-qubit in-flight state and the funct-to-gate decoder.
package qpu_pkg;

    localparam logic [2:0] GATE_I = 3'b000;
    localparam logic [2:0] GATE_H = 3'b001;
    localparam logic [2:0] GATE_X = 3'b010;
    localparam logic [2:0] GATE_Z = 3'b011;
    localparam logic [2:0] GATE_Y = 3'b100;

    localparam logic [5:0] OPC_COP2 = 6'b010010;

    localparam logic [5:0] F_QH = 6'd1;
    localparam logic [5:0] F_QX = 6'd2;
    localparam logic [5:0] F_QZ = 6'd3;
    localparam logic [5:0] F_QY = 6'd4;

    localparam int QF_HI = 15;
    localparam int QF_LO = 11;

    typedef enum logic {
        Q_FREE   = 1'b0,
        Q_ISSUED = 1'b1
    } qstate_e;

    // GATE_I marks an unsupported funct, so callers can test legality on the result.
    function automatic logic [2:0] funct_to_gate(input logic [5:0] funct);
        logic [2:0] g;
        case (funct)
            F_QH:    g = GATE_H;
            F_QX:    g = GATE_X;
            F_QZ:    g = GATE_Z;
            F_QY:    g = GATE_Y;
            default: g = GATE_I;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/qpu_cmd_fifo.sv
// Synchronous command FIFO with separate occupancy counter; pointers wrap
// modulo DEPTH, push is ignored when full and pop when empty.
module qpu_cmd_fifo
    import qpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        else           wr_ptr_d = wr_ptr_q;
        if (pop_ok_s)  rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        else           rd_ptr_d = rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only consumed when count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/qpu_issue_queue.sv
// In-order COP2 issue queue: decodes quantum instructions, buffers them and
// pulses one gate command per cycle to a free, non-busy quantum controller.
module qpu_issue_queue
    import qpu_pkg::*;
#(
    parameter int NUM_QUBITS = 4,
    parameter int DEPTH      = 8,
    parameter int QIDX_W     = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic [31:0]               instr,
    input  logic                      quantum_en,
    output logic                      stall,
    input  logic [NUM_QUBITS-1:0]     qb_busy,
    output logic [NUM_QUBITS-1:0]     cmd_execute,
    output logic [2:0]                cmd_gate,
    output logic [QIDX_W-1:0]         cmd_qubit,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      illegal,
    output logic                      idle
);

    localparam int         ENTRY_W = 3 + QIDX_W;
    localparam logic [5:0] NQ_L    = 6'(NUM_QUBITS);

    logic [4:0]            qfield_s;
    logic [2:0]            gate_s;
    logic                  legal_s, accept_s, push_s, issue_s;
    logic                  full_s, empty_s, any_inflight_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [2:0]            head_gate_s;
    logic [QIDX_W-1:0]     head_qubit_s;
    logic                  unused_instr_s;

    qstate_e               state_q [NUM_QUBITS];
    qstate_e               state_d [NUM_QUBITS];
    logic [NUM_QUBITS-1:0] cmd_execute_q, cmd_execute_d;
    logic [2:0]            cmd_gate_q, cmd_gate_d;
    logic [QIDX_W-1:0]     cmd_qubit_q, cmd_qubit_d;
    logic                  illegal_q, illegal_d;

    assign qfield_s       = instr[QF_HI:QF_LO];
    assign gate_s         = funct_to_gate(instr[5:0]);
    assign legal_s        = (gate_s != GATE_I) && ({1'b0, qfield_s} < NQ_L);
    assign accept_s       = instr_valid & quantum_en & ~full_s;
    assign push_s         = accept_s & legal_s;
    assign unused_instr_s = ^{instr[31:16], instr[10:6]};

    qpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_s),
        .pop_i   (issue_s),
        .data_i  ({gate_s, qfield_s[QIDX_W-1:0]}),
        .data_o  (head_s),
        .count_o (fifo_count),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign head_gate_s  = head_s[ENTRY_W-1:QIDX_W];
    assign head_qubit_s = head_s[QIDX_W-1:0];
    // Only the head may issue, which keeps program order across qubits.
    assign issue_s      = ~empty_s & ~qb_busy[head_qubit_s] & (state_q[head_qubit_s] == Q_FREE);

    always_comb begin
        any_inflight_s = 1'b0;
        for (int q = 0; q < NUM_QUBITS; q++) begin
            state_d[q] = state_q[q];
            case (state_q[q])
                Q_FREE: begin
                    if (issue_s && (head_qubit_s == QIDX_W'(q))) state_d[q] = Q_ISSUED;
                    else                                         state_d[q] = Q_FREE;
                end
                // Once busy is seen the controller itself blocks further issue.
                Q_ISSUED: begin
                    if (qb_busy[q]) state_d[q] = Q_FREE;
                    else            state_d[q] = Q_ISSUED;
                    any_inflight_s = 1'b1;
                end
                default: state_d[q] = Q_FREE;
            endcase
        end
    end

    always_comb begin
        cmd_execute_d = {NUM_QUBITS{1'b0}};
        cmd_gate_d    = cmd_gate_q;
        cmd_qubit_d   = cmd_qubit_q;
        illegal_d     = illegal_q | (accept_s & ~legal_s);
        if (issue_s) begin
            cmd_execute_d[head_qubit_s] = 1'b1;
            cmd_gate_d                  = head_gate_s;
            cmd_qubit_d                 = head_qubit_s;
        end else begin
            cmd_execute_d = {NUM_QUBITS{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int q = 0; q < NUM_QUBITS; q++) state_q[q] <= Q_FREE;
            cmd_execute_q <= {NUM_QUBITS{1'b0}};
            cmd_gate_q    <= GATE_I;
            cmd_qubit_q   <= {QIDX_W{1'b0}};
            illegal_q     <= 1'b0;
        end else begin
            for (int q = 0; q < NUM_QUBITS; q++) state_q[q] <= state_d[q];
            cmd_execute_q <= cmd_execute_d;
            cmd_gate_q    <= cmd_gate_d;
            cmd_qubit_q   <= cmd_qubit_d;
            illegal_q     <= illegal_d;
        end
    end

    assign cmd_execute = cmd_execute_q;
    assign cmd_gate    = cmd_gate_q;
    assign cmd_qubit   = cmd_qubit_q;
    assign illegal     = illegal_q;
    assign stall       = full_s;
    assign idle        = empty_s & ~any_inflight_s;

endmodule
